// File: rtl/filter_mac_acc.sv
// filter_mac_acc: NTAPS-deep sample delay line with a serial multiply-accumulate over
// coefficients fetched from a synchronous-read RAM; one result per accepted sample.
module filter_mac_acc #(
  parameter int NTAPS  = 16,
  parameter int TAP_AW = 4
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     sample_strobe,
  input  logic signed [15:0]       sample_in,
  input  logic                     dl_clear,
  output logic [TAP_AW-1:0]        coef_addr,
  input  logic signed [15:0]       coef_data,
  output logic signed [39:0]       acc_out,
  output logic                     final_state,
  output logic                     busy,
  output logic                     sample_drop
);
  typedef enum logic [1:0] {IDLE, PRIME, MAC, DONE} state_t;
  localparam logic [TAP_AW-1:0] LAST = TAP_AW'(NTAPS - 1);
  state_t              state_q, state_d;
  logic signed [15:0]  x_q [NTAPS];
  logic signed [15:0]  x_d [NTAPS];
  logic signed [39:0]  acc_q, acc_d;
  logic [TAP_AW-1:0]   tap_q, tap_d, addr_q, addr_d;
  logic                drop_q, drop_d;
  logic signed [31:0]  prod;
  logic [TAP_AW:0]     nxt_addr;
  logic                accept;
  assign coef_addr   = addr_q;
  assign acc_out     = acc_q;
  assign final_state = state_q == DONE;
  assign busy        = state_q == PRIME || state_q == MAC;
  assign sample_drop = drop_q;
  always_comb begin
    accept   = sample_strobe && (state_q == IDLE || state_q == DONE);
    prod     = 32'(coef_data) * 32'(x_q[tap_q]);
    nxt_addr = {1'b0, tap_q} + (TAP_AW + 1)'(2);
    state_d  = state_q;
    x_d      = x_q;
    acc_d    = acc_q;
    tap_d    = tap_q;
    addr_d   = addr_q;
    drop_d   = sample_strobe && busy;
    if (accept) begin
      x_d[0] = sample_in;
      for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
      acc_d   = '0;
      tap_d   = '0;
      addr_d  = '0;
      state_d = PRIME;
    end else if (state_q == IDLE && dl_clear) begin
      for (int k = 0; k < NTAPS; k++) x_d[k] = '0;
    end else if (state_q == PRIME) begin
      addr_d  = TAP_AW'(1);
      state_d = MAC;
    end else if (state_q == MAC) begin
      acc_d   = acc_q + {{8{prod[31]}}, prod};
      tap_d   = tap_q + 1'b1;
      // Prefetch two taps ahead to cover the RAM read latency; clamp past the end.
      addr_d  = (nxt_addr > {1'b0, LAST}) ? LAST : nxt_addr[TAP_AW-1:0];
      state_d = (tap_q == LAST) ? DONE : MAC;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      acc_q   <= '0;
      tap_q   <= '0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end
endmodule
